// File: rtl/ramd64_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ramd64_fifo_ctrl_if
// Request/status bundle between a FIFO user and the RAMD64 FIFO controller.
//   clr          : synchronous flush request
//   wr_en        : write request (data goes straight to the RAM I pins)
//   rd_en        : read request, pops the head word
//   wadr / radr  : 6-bit write / read addresses to the RAM array
//   we           : RAM write enable (combinational, accepted write)
//   full, empty  : occupancy flags
//   count        : occupancy 0..64
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   overflow     : sticky, set by a rejected write
//   underflow    : sticky, set by a read of an empty FIFO
// master = FIFO user, slave = controller.
// ---------------------------------------------------------------------------
interface ramd64_fifo_ctrl_if;
  logic       clr;
  logic       wr_en;
  logic       rd_en;
  logic [5:0] wadr;
  logic [5:0] radr;
  logic       we;
  logic       full;
  logic       empty;
  logic [6:0] count;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  modport master (
    output clr, wr_en, rd_en,
    input  wadr, radr, we, full, empty, count,
    input  almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, rd_en,
    output wadr, radr, we, full, empty, count,
    output almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/ramd64_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ramd64_fifo_ctrl
// Pointer/flag controller that turns a 64-deep array of RAMD64 cells (one
// cell per data bit) into a first-word-fall-through FIFO. The head word is
// always visible at the array O pins (addressed by radr) while empty=0.
//
// Parameters
//   AF_LEVEL : almost_full asserts when count >= AF_LEVEL (1..63)
//   AE_LEVEL : almost_empty asserts when count <= AE_LEVEL (0..62)
// Ports
//   clk   : single clock, all state changes on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/status bundle (slave side), see ramd64_fifo_ctrl_if
// ---------------------------------------------------------------------------
module ramd64_fifo_ctrl #(
  parameter int AF_LEVEL = 56,
  parameter int AE_LEVEL = 8
) (
  input logic                clk,
  input logic                rst_n,
  ramd64_fifo_ctrl_if.slave  bus
);

  localparam logic [6:0] AF_THR = 7'(AF_LEVEL);
  localparam logic [6:0] AE_THR = 7'(AE_LEVEL);
  localparam logic [6:0] DEPTH  = 7'd64;

  logic [6:0] wr_ptr;
  logic [6:0] rd_ptr;
  logic [6:0] count_q;
  logic [6:0] count_nxt;
  logic       full_q;
  logic       empty_q;
  logic       af_q;
  logic       ae_q;
  logic       ovf_q;
  logic       udf_q;
  logic       rd_ok;
  logic       wr_ok;

  // Request acceptance. A read needs data and no flush; a write needs room,
  // except that a full FIFO can take a write in the same cycle as a pop,
  // because the popped slot is exactly the one being overwritten.
  always_comb begin
    rd_ok     = bus.rd_en & ~empty_q & ~bus.clr;
    wr_ok     = bus.wr_en & ~bus.clr & (~full_q | rd_ok);
    count_nxt = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count_q + 7'd1;
      2'b01:   count_nxt = count_q - 7'd1;
      default: count_nxt = count_q;
    endcase
  end

  // Pointers, occupancy and flags. The flags are registered copies of the
  // next count, so they line up with count on every edge. The 7-bit
  // pointers let full (MSBs differ) be told apart from empty (MSBs equal)
  // when the 6-bit addresses coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 7'd1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 7'd1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH);
      empty_q <= (count_nxt == 7'd0);
      af_q    <= (count_nxt >= AF_THR);
      ae_q    <= (count_nxt <= AE_THR);
      if (bus.wr_en && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (bus.rd_en && empty_q) begin
        udf_q <= 1'b1;
      end
    end
  end

  // The RAM captures on the same edge the write pointer advances. Gating
  // with rst_n kills a write the moment reset is asserted, even though the
  // request inputs themselves are still active.
  assign bus.we           = wr_ok & rst_n;
  assign bus.wadr         = wr_ptr[5:0];
  assign bus.radr         = rd_ptr[5:0];
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_ramd64_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ramd64_fifo_ctrl
// Self-checking bench for ramd64_fifo_ctrl. An 8-bit wide behavioural RAM
// stands in for the RAMD64 array so that head data and ordering can be
// checked through the controller's addresses.
// ---------------------------------------------------------------------------
module tb_ramd64_fifo_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] wdata = 8'd0;
  logic [7:0] ram [64];
  logic [7:0] head;
  logic       we_pre;
  logic [7:0] model_q [$];
  int         checks   = 0;
  int         failures = 0;

  ramd64_fifo_ctrl_if bus();

  ramd64_fifo_ctrl #(.AF_LEVEL(56), .AE_LEVEL(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Behavioural RAM array: synchronous write, asynchronous read.
  always @(posedge clk) begin
    if (bus.we) ram[bus.wadr] <= wdata;
  end
  assign head = ram[bus.radr];

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    logic       exp_we;
    logic [6:0] exp_count;
    logic [5:0] exp_wadr;
    logic [5:0] exp_radr;
    logic       exp_empty;
    logic       exp_udf;
    logic [7:0] exp_head;
  } vec_t;

  vec_t vecs [12];

  // Compare one value and log a failure.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one request set after the falling edge, sample WE before the
  // rising edge, then let the edge happen and settle for 1 ns.
  task automatic applyStimulus(input logic wr, input logic rd, input logic clr,
                               input logic [7:0] d, output logic we_seen);
    @(negedge clk);
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.clr   = clr;
    wdata     = d;
    #1 we_seen = bus.we;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  // Reset-state checks shared by several sequences.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"}, 32'(bus.count), 0);
    checkOutput({tag, "_empty"}, 32'(bus.empty), 1);
    checkOutput({tag, "_ae"},    32'(bus.almost_empty), 1);
    checkOutput({tag, "_full"},  32'(bus.full), 0);
    checkOutput({tag, "_af"},    32'(bus.almost_full), 0);
    checkOutput({tag, "_ovf"},   32'(bus.overflow), 0);
    checkOutput({tag, "_udf"},   32'(bus.underflow), 0);
    checkOutput({tag, "_wadr"},  32'(bus.wadr), 0);
    checkOutput({tag, "_radr"},  32'(bus.radr), 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
  endtask

  // Main test sequence.
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;

    //               wr   rd   clr  din    we   cnt   wadr  radr  emp  udf  head
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 7'd1, 6'd1, 6'd0, 1'b0, 1'b0, 8'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 7'd2, 6'd2, 6'd0, 1'b0, 1'b0, 8'd1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 7'd3, 6'd3, 6'd0, 1'b0, 1'b0, 8'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 7'd2, 6'd3, 6'd1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'd5, 1'b1, 7'd2, 6'd4, 6'd2, 1'b0, 1'b0, 8'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 7'd1, 6'd4, 6'd3, 1'b0, 1'b0, 8'd5};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 7'd0, 6'd4, 6'd4, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 7'd0, 6'd4, 6'd4, 1'b1, 1'b1, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'd9, 1'b1, 7'd1, 6'd5, 6'd4, 1'b0, 1'b1, 8'd9};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'd3, 1'b0, 7'd0, 6'd0, 6'd0, 1'b1, 1'b0, 8'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 7'd0, 6'd0, 6'd0, 1'b1, 1'b1, 8'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd7, 1'b1, 7'd1, 6'd1, 6'd0, 1'b0, 1'b1, 8'd7};

    // Asynchronous reset, with a write request held active throughout.
    #2 rst_n = 1'b0;
    bus.wr_en = 1'b1;
    #1;
    checkResetState("rst_async");
    checkOutput("rst_we", 32'(bus.we), 0);
    repeat (2) @(posedge clk);
    #1;
    checkResetState("rst_held");
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven basic sequence.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din, we_pre);
      checkOutput($sformatf("v%0d_we", i),    32'(we_pre),        32'(vecs[i].exp_we));
      checkOutput($sformatf("v%0d_count", i), 32'(bus.count),     32'(vecs[i].exp_count));
      checkOutput($sformatf("v%0d_wadr", i),  32'(bus.wadr),      32'(vecs[i].exp_wadr));
      checkOutput($sformatf("v%0d_radr", i),  32'(bus.radr),      32'(vecs[i].exp_radr));
      checkOutput($sformatf("v%0d_empty", i), 32'(bus.empty),     32'(vecs[i].exp_empty));
      checkOutput($sformatf("v%0d_udf", i),   32'(bus.underflow), 32'(vecs[i].exp_udf));
      checkOutput($sformatf("v%0d_full", i),  32'(bus.full),      0);
      checkOutput($sformatf("v%0d_ovf", i),   32'(bus.overflow),  0);
      if (!vecs[i].exp_empty)
        checkOutput($sformatf("v%0d_head", i), 32'(head), 32'(vecs[i].exp_head));
    end

    // Fill to 64 with no reads, watching the threshold flags.
    pulseReset();
    checkResetState("rst_pulse");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(i * 3 + 1), we_pre);
      model_q.push_back(8'(i * 3 + 1));
      checkOutput($sformatf("fill%0d_we", i),    32'(we_pre), 1);
      checkOutput($sformatf("fill%0d_count", i), 32'(bus.count), i + 1);
      checkOutput($sformatf("fill%0d_full", i),  32'(bus.full), (i + 1 == 64) ? 1 : 0);
      checkOutput($sformatf("fill%0d_af", i),    32'(bus.almost_full), (i + 1 >= 56) ? 1 : 0);
      checkOutput($sformatf("fill%0d_ae", i),    32'(bus.almost_empty), (i + 1 <= 8) ? 1 : 0);
      checkOutput($sformatf("fill%0d_head", i),  32'(head), 32'(model_q[0]));
    end

    // Lone write into a full FIFO is rejected and must not touch RAM slot 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE, we_pre);
    checkOutput("ovf_we",    32'(we_pre), 0);
    checkOutput("ovf_flag",  32'(bus.overflow), 1);
    checkOutput("ovf_count", 32'(bus.count), 64);
    checkOutput("ovf_full",  32'(bus.full), 1);
    checkOutput("ovf_wadr",  32'(bus.wadr), 0);
    checkOutput("ovf_head",  32'(head), 32'(model_q[0]));

    // Full FIFO, simultaneous write and read for 70 cycles.
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(100 + i), we_pre);
      void'(model_q.pop_front());
      model_q.push_back(8'(100 + i));
      checkOutput($sformatf("rw%0d_we", i),    32'(we_pre), 1);
      checkOutput($sformatf("rw%0d_count", i), 32'(bus.count), 64);
      checkOutput($sformatf("rw%0d_full", i),  32'(bus.full), 1);
      checkOutput($sformatf("rw%0d_head", i),  32'(head), 32'(model_q[0]));
    end
    checkOutput("rw_wadr", 32'(bus.wadr), 6);
    checkOutput("rw_radr", 32'(bus.radr), 6);
    checkOutput("rw_ovf",  32'(bus.overflow), 1);

    // Drain down to 20 entries, checking order.
    for (int i = 0; i < 44; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, we_pre);
      void'(model_q.pop_front());
      checkOutput($sformatf("drain%0d_count", i), 32'(bus.count), 63 - i);
      checkOutput($sformatf("drain%0d_head", i),  32'(head), 32'(model_q[0]));
    end
    checkOutput("drain_af", 32'(bus.almost_full), 0);
    checkOutput("drain_ae", 32'(bus.almost_empty), 0);

    // Flush with a write request present: write is suppressed.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h55, we_pre);
    model_q.delete();
    checkOutput("clr_we", 32'(we_pre), 0);
    checkResetState("clr");

    // Reset pulsed between edges aborts an in-flight write immediately;
    // the request is then honoured on the first edge after release.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(i + 40), we_pre);
    checkOutput("pre_rst_count", 32'(bus.count), 3);
    @(negedge clk);
    bus.wr_en = 1'b1;
    wdata     = 8'h77;
    #1 checkOutput("mid_we_before", 32'(bus.we), 1);
    #1 rst_n = 1'b0;
    #1;
    checkResetState("mid_rst");
    checkOutput("mid_we_during", 32'(bus.we), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    checkOutput("post_rst_count", 32'(bus.count), 1);
    checkOutput("post_rst_wadr",  32'(bus.wadr), 1);
    checkOutput("post_rst_head",  32'(head), 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
